// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared opcodes, transfer sizes and FSM states for mem_access
package mem_access_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
            default:              return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-side SRAM-like request/response bus
interface mem_access_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane select and sign/zero extension
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half lane, then extend according to the opcode
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        value    = 32'h0;
        case (op)
            OP_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  value = {24'h0, byte_sel};
            OP_LH:   value = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  value = {16'h0, half_sel};
            OP_LW:   value = rdata;
            default: value = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage load/store unit (optional MEM_ADDR_EXC_EN alignment exceptions)
module mem_access
    import mem_access_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  instrM,
    input  logic [31:0]  alu_outM,
    input  logic [31:0]  rt_valueM,
    input  logic         flushM,
    input  logic         stallM,
    mem_access_if.master bus,
    output logic [31:0]  load_valueM,
    output logic         mem_stallM,
    output logic         adelM,
    output logic         adesM
);

    state_t      state, state_n;
    logic [5:0]  op;
    logic        is_load, is_store, mem_op, addr_err, go;
    logic        req, capture;
    logic [1:0]  size;
    logic [31:0] wdata_lanes, rdata_q, aligned;
    logic        unused_instr;

    assign op           = instrM[31:26];
    assign unused_instr = ^instrM[25:0];
    assign is_load      = is_load_op(op);
    assign is_store     = is_store_op(op);
    assign mem_op       = is_load | is_store;
    assign size         = op_size(op);

`ifdef MEM_ADDR_EXC_EN
    logic misaligned;
    assign misaligned = ((size == SIZE_HALF) && alu_outM[0]) ||
                        ((size == SIZE_WORD) && (alu_outM[1:0] != 2'b00));
    assign adelM = is_load & misaligned;
    assign adesM = is_store & misaligned;
`else
    assign adelM = 1'b0;
    assign adesM = 1'b0;
`endif

    assign addr_err = adelM | adesM;
    assign go       = mem_op & ~flushM & ~addr_err;

    // State register; reset abandons any bus transaction since the bus resets too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next state, request strobe and response capture
    always_comb begin
        state_n = state;
        req     = 1'b0;
        capture = 1'b0;
        case (state)
            ST_IDLE, ST_REQ: begin
                // REQ keeps the request up until accepted; a flush withdraws it at once
                req = (state == ST_IDLE) ? go : ~flushM;
                if (state == ST_REQ && flushM) begin
                    state_n = ST_IDLE;
                end else if (req) begin
                    if (bus.data_addr_ok && bus.data_data_ok) begin
                        state_n = ST_DONE;
                        capture = 1'b1;
                    end else if (bus.data_addr_ok) begin
                        state_n = ST_WAIT;
                    end else begin
                        state_n = ST_REQ;
                    end
                end
            end
            ST_WAIT: begin
                // An accepted request always consumes its data_ok, even when flushed
                if (bus.data_data_ok) begin
                    if (flushM) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DONE;
                        capture = 1'b1;
                    end
                end else if (flushM) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (flushM || !stallM) state_n = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.data_data_ok) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Response capture register feeding the load aligner
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rdata_q <= 32'h0;
        else if (capture) rdata_q <= bus.data_rdata;
    end

    // Store data replicated across the lanes the size covers
    always_comb begin
        case (size)
            SIZE_BYTE: wdata_lanes = {4{rt_valueM[7:0]}};
            SIZE_HALF: wdata_lanes = {2{rt_valueM[15:0]}};
            default:   wdata_lanes = rt_valueM;
        endcase
    end

    assign bus.data_req   = req;
    assign bus.data_wr    = req & is_store;
    assign bus.data_size  = req ? size : SIZE_BYTE;
    assign bus.data_addr  = req ? alu_outM : 32'h0;
    assign bus.data_wdata = (req && is_store) ? wdata_lanes : 32'h0;

    mem_load_align u_align (
        .op      (op),
        .addr_lo (alu_outM[1:0]),
        .rdata   (rdata_q),
        .value   (aligned)
    );

    assign load_valueM = (state == ST_DONE) ? aligned : 32'h0;
    assign mem_stallM  = (go && state != ST_DONE) || (state == ST_DRAIN);

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed vector bench for mem_access
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instrM = 32'h0;
    logic [31:0] alu_outM = 32'h0;
    logic [31:0] rt_valueM = 32'h0;
    logic        flushM = 1'b0;
    logic        stallM = 1'b0;
    logic [31:0] load_valueM;
    logic        mem_stallM, adelM, adesM;

    mem_access_if bus();

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .instrM      (instrM),
        .alu_outM    (alu_outM),
        .rt_valueM   (rt_valueM),
        .flushM      (flushM),
        .stallM      (stallM),
        .bus         (bus.master),
        .load_valueM (load_valueM),
        .mem_stallM  (mem_stallM),
        .adelM       (adelM),
        .adesM       (adesM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic        same;
        logic [1:0]  exp_size;
        logic        exp_wr;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        instrM = 32'h0; alu_outM = 32'h0; rt_valueM = 32'h0;
        flushM = 1'b0; stallM = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt);
        instrM = {op, 26'h0}; alu_outM = addr; rt_valueM = rt;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(posedge clk); #1;
        set_instr(v.op, v.addr, v.rt);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = v.same;
        bus.data_rdata   = v.same ? v.rdata : 32'h0;
        #1;
        check($sformatf("v%0d_req", idx), bus.data_req, 1);
        check($sformatf("v%0d_wr", idx), bus.data_wr, v.exp_wr);
        check($sformatf("v%0d_size", idx), bus.data_size, v.exp_size);
        check($sformatf("v%0d_addr", idx), bus.data_addr, v.addr);
        if (v.exp_wr) check($sformatf("v%0d_wdata", idx), bus.data_wdata, v.exp_val);
        check($sformatf("v%0d_stall_c0", idx), mem_stallM, 1);
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        if (!v.same) begin
            #1;
            check($sformatf("v%0d_stall_c1", idx), mem_stallM, 1);
            check($sformatf("v%0d_req_wait", idx), bus.data_req, 0);
            bus.data_data_ok = 1'b1; bus.data_rdata = v.rdata;
            @(posedge clk); #1;
            bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        end
        #1;
        check($sformatf("v%0d_stall_done", idx), mem_stallM, 0);
        if (!v.exp_wr) check($sformatf("v%0d_load", idx), load_valueM, v.exp_val);
        @(posedge clk); #1;
        drive_idle();
        #1;
        check($sformatf("v%0d_load_idle", idx), load_valueM, 0);
    endtask

    initial begin
        vecs[0] = '{OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, SIZE_WORD, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{OP_LB,  32'h103, 32'h0,        32'h80FF1234, 1'b0, SIZE_BYTE, 1'b0, 32'hFFFFFF80};
        vecs[2] = '{OP_LBU, 32'h103, 32'h0,        32'h80FF1234, 1'b0, SIZE_BYTE, 1'b0, 32'h00000080};
        vecs[3] = '{OP_LH,  32'h102, 32'h0,        32'h80FF1234, 1'b0, SIZE_HALF, 1'b0, 32'hFFFF80FF};
        vecs[4] = '{OP_LHU, 32'h100, 32'h0,        32'h80FF1234, 1'b1, SIZE_HALF, 1'b0, 32'h00001234};
        vecs[5] = '{OP_LB,  32'h101, 32'h0,        32'h80FF1234, 1'b1, SIZE_BYTE, 1'b0, 32'h00000012};
        vecs[6] = '{OP_SB,  32'h201, 32'h000000AB, 32'h0,        1'b0, SIZE_BYTE, 1'b1, 32'hABABABAB};
        vecs[7] = '{OP_SH,  32'h202, 32'h1234CDEF, 32'h0,        1'b1, SIZE_HALF, 1'b1, 32'hCDEFCDEF};
        vecs[8] = '{OP_SW,  32'h204, 32'hCAFEF00D, 32'h0,        1'b0, SIZE_WORD, 1'b1, 32'hCAFEF00D};
        vecs[9] = '{OP_LH,  32'h100, 32'h0,        32'h7FFF8001, 1'b1, SIZE_HALF, 1'b0, 32'hFFFF8001};

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", bus.data_req, 0);
        check("rst_wr", bus.data_wr, 0);
        check("rst_size", bus.data_size, 0);
        check("rst_addr", bus.data_addr, 0);
        check("rst_wdata", bus.data_wdata, 0);
        check("rst_load", load_valueM, 0);
        check("rst_stall", mem_stallM, 0);
        check("rst_adel", adelM, 0);
        check("rst_ades", adesM, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // LW stuck in REQ for 3 cycles, then flushed
        @(posedge clk); #1;
        set_instr(OP_LW, 32'h300, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("req_hold_c%0d", c), bus.data_req, 1);
            check($sformatf("req_stall_c%0d", c), mem_stallM, 1);
            @(posedge clk); #1;
        end
        flushM = 1'b1;
        #1;
        check("req_flush_drop", bus.data_req, 0);
        check("req_flush_stall", mem_stallM, 0);
        @(posedge clk); #1;
        drive_idle();
        #1;
        check("req_flush_idle", bus.data_req, 0);

        // Flush in WAIT, new LW must wait for the stale response
        @(posedge clk); #1;
        set_instr(OP_LW, 32'h400, 32'h0);
        bus.data_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0;
        flushM = 1'b1;
        @(posedge clk); #1;
        flushM = 1'b0;
        set_instr(OP_LW, 32'h500, 32'h0);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBADBAD00;
            end
            #1;
            check($sformatf("drain_req_c%0d", c), bus.data_req, 0);
            check($sformatf("drain_stall_c%0d", c), mem_stallM, 1);
            check($sformatf("drain_load_c%0d", c), load_valueM, 0);
            @(posedge clk); #1;
        end
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        #1;
        check("drain_new_req", bus.data_req, 1);
        check("drain_new_addr", bus.data_addr, 32'h500);
        bus.data_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h11223344;
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        #1;
        check("drain_new_load", load_valueM, 32'h11223344);
        check("drain_new_stall", mem_stallM, 0);

        // DONE held by an external stall keeps the load value
        stallM = 1'b1;
        @(posedge clk); #1;
        check("done_hold_load", load_valueM, 32'h11223344);
        check("done_hold_stall", mem_stallM, 0);
        stallM = 1'b0;
        @(posedge clk); #1;
        drive_idle();

        // Stray data_ok in IDLE is ignored
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55555555;
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0;
        #1;
        check("stray_ok_load", load_valueM, 0);
        check("stray_ok_stall", mem_stallM, 0);

        // Misaligned accesses
        @(posedge clk); #1;
        set_instr(OP_LW, 32'h102, 32'h0);
        #1;
`ifdef MEM_ADDR_EXC_EN
        check("mis_lw_adel", adelM, 1);
        check("mis_lw_req", bus.data_req, 0);
        check("mis_lw_stall", mem_stallM, 0);
        set_instr(OP_SH, 32'h101, 32'h0);
        #1;
        check("mis_sh_ades", adesM, 1);
        check("mis_sh_req", bus.data_req, 0);
`else
        check("mis_lw_adel", adelM, 0);
        check("mis_lw_req", bus.data_req, 1);
        check("mis_lw_addr", bus.data_addr, 32'h102);
        bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h01020304;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        #1;
        check("mis_lw_load", load_valueM, 32'h01020304);
        @(posedge clk); #1;
        set_instr(OP_SH, 32'h101, 32'h0);
        #1;
        check("mis_sh_ades", adesM, 0);
        check("mis_sh_req", bus.data_req, 1);
        bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1;
        @(posedge clk); #1;
`endif
        drive_idle();

        // Reset while a load waits for its response
        @(posedge clk); #1;
        set_instr(OP_LW, 32'h600, 32'h0);
        bus.data_addr_ok = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_stall", mem_stallM, 0);
        check("midrst_req", bus.data_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_vec(20, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
